coin_acceptor: RTL and testbench

- Front-end stage that feeds the vending FSM's 2-bit coin input.
- Synchronises and debounces the raw coin-sensor line and measures each pulse width in clock cycles.
- Classifies each pulse as 5-unit, 10-unit or invalid, and emits a single-cycle coin code (00 none, 01 five, 10 ten; 11 never driven).
- Also reports rejects, sensor jams and a busy status.

---
 rtl/vm_pkg.sv | 8 +
 rtl/sync_debounce.sv | 35 +++
 rtl/coin_acceptor.sv | 125 ++++++++++++
 tb/tb_coin_acceptor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Definitions shared between the coin acceptor front end and the vending FSM.
package vm_pkg;
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {IDLE, MEASURE, JAM, GAP} acc_state_t;
endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a persistence-count debouncer.
module sync_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);
    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic          s1, s2;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // db follows s2 only after it has differed on DEB_CYCLES edges in a row
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == DW'(DEB_CYCLES - 1)) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/coin_acceptor.sv
// Measures debounced coin-sensor pulses and turns them into one-cycle coin codes,
// rejects and jam status for the vending FSM.
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int W5_MIN     = 20,
    parameter int W5_MAX     = 40,
    parameter int W10_MIN    = 60,
    parameter int W10_MAX    = 100,
    parameter int JAM_CYCLES = 255,
    parameter int GAP_CYCLES = 16,
    parameter int CW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin_sense,
    input  logic          accept_en,
    output logic [1:0]    coin,
    output logic          reject,
    output logic          jam,
    output logic          busy,
    output logic [CW-1:0] reject_cnt
);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic          db;
    acc_state_t    state, state_n;
    logic [CW-1:0] wcnt, wcnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic          bad, bad_n;
    logic [1:0]    coin_n;
    logic          reject_n, jam_n;

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk (clk),
        .rst (rst),
        .raw (coin_sense),
        .db  (db)
    );

    always_comb begin
        state_n  = state;
        wcnt_n   = wcnt;
        gcnt_n   = gcnt;
        bad_n    = bad;
        coin_n   = COIN_NONE;
        reject_n = 1'b0;
        jam_n    = jam;
        case (state)
            IDLE: begin
                if (db) begin
                    state_n = MEASURE;
                    wcnt_n  = CW'(1);
                    bad_n   = ~accept_en;
                end
            end
            MEASURE: begin
                if (db) begin
                    wcnt_n = wcnt + 1'b1;
                    bad_n  = bad | ~accept_en;
                    if (wcnt + 1'b1 == CW'(JAM_CYCLES)) begin
                        state_n = JAM;
                        jam_n   = 1'b1;
                    end
                end else begin
                    if (!bad && wcnt >= CW'(W5_MIN) && wcnt <= CW'(W5_MAX))
                        coin_n = COIN_5;
                    else if (!bad && wcnt >= CW'(W10_MIN) && wcnt <= CW'(W10_MAX))
                        coin_n = COIN_10;
                    else
                        reject_n = 1'b1;
                    state_n = GAP;
                    gcnt_n  = '0;
                end
            end
            JAM: begin
                if (!db) begin
                    jam_n    = 1'b0;
                    reject_n = 1'b1;
                    state_n  = GAP;
                    gcnt_n   = '0;
                end
            end
            GAP: begin
                // a pulse arriving during the quiet time is measured but always rejected
                if (db) begin
                    state_n = MEASURE;
                    wcnt_n  = CW'(1);
                    bad_n   = 1'b1;
                end else if (gcnt == GW'(GAP_CYCLES - 1)) begin
                    state_n = IDLE;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wcnt       <= '0;
            gcnt       <= '0;
            bad        <= 1'b0;
            coin       <= COIN_NONE;
            reject     <= 1'b0;
            jam        <= 1'b0;
            reject_cnt <= '0;
        end else begin
            state  <= state_n;
            wcnt   <= wcnt_n;
            gcnt   <= gcnt_n;
            bad    <= bad_n;
            coin   <= coin_n;
            reject <= reject_n;
            jam    <= jam_n;
            if (reject_n && reject_cnt != {CW{1'b1}})
                reject_cnt <= reject_cnt + 1'b1;
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: pulse widths, windows, glitches, jam, gap and reset.
module tb_coin_acceptor;
    logic       clk = 1'b0;
    logic       rst, coin_sense, accept_en;
    logic [1:0] coin;
    logic       reject, jam, busy;
    logic [7:0] reject_cnt;

    int vectors = 0;
    int errors  = 0;

    // per-pulse observations
    int n5, n10, n11, nrej, both, coin_edge, fall_k, busy_any, jam_seen;
    logic busy_tail [0:63];

    coin_acceptor dut (
        .clk(clk), .rst(rst), .coin_sense(coin_sense), .accept_en(accept_en),
        .coin(coin), .reject(reject), .jam(jam), .busy(busy), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (fall_k >= 0) fall_k++;
        if (coin == 2'b01) begin n5++;  if (coin_edge < 0) coin_edge = fall_k; end
        if (coin == 2'b10) begin n10++; if (coin_edge < 0) coin_edge = fall_k; end
        if (coin == 2'b11) n11++;
        if (reject) nrej++;
        if (reject && coin != 2'b00) both++;
        if (busy) busy_any++;
        if (jam) jam_seen++;
        if (fall_k >= 0 && fall_k < 64) busy_tail[fall_k] = busy;
    endtask

    task automatic clear_stats();
        n5 = 0; n10 = 0; n11 = 0; nrej = 0; both = 0; coin_edge = -1;
        fall_k = -1; busy_any = 0; jam_seen = 0;
        for (int i = 0; i < 64; i++) busy_tail[i] = 1'b0;
    endtask

    // raw high for w edges (drop_at: cycle with accept_en low, -1 for none), then tail low edges
    task automatic drive_pulse(input int w, input int tail, input int drop_at);
        clear_stats();
        coin_sense = 1'b1;
        for (int i = 0; i < w; i++) begin
            accept_en = (i == drop_at) ? 1'b0 : 1'b1;
            step();
        end
        coin_sense = 1'b0;
        accept_en  = 1'b1;
        fall_k     = 0;
        for (int k = 0; k < tail; k++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; coin_sense = 1'b0; accept_en = 1'b1;
        clear_stats();
        repeat (3) step();
        rst = 1'b0;
        vectors++;
        if ({coin, reject, jam, busy, reject_cnt} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got coin=%b rej=%b jam=%b busy=%b cnt=%0d, want all 0",
                     coin, reject, jam, busy, reject_cnt);
        end
    endtask

    task automatic test_coin5();
        drive_pulse(30, 30, -1);
        vectors++;
        if (n5 !== 1 || n10 !== 0 || nrej !== 0) begin
            errors++;
            $display("FAIL coin5_count: n5=%0d n10=%0d rej=%0d, want 1/0/0", n5, n10, nrej);
        end
        vectors++;
        if (coin_edge !== 7) begin
            errors++;
            $display("FAIL coin5_latency: edge %0d after fall, want 7", coin_edge);
        end
        vectors++;
        if (reject_cnt !== 8'd0) begin
            errors++;
            $display("FAIL coin5_rejcnt: got %0d want 0", reject_cnt);
        end
        vectors++;
        if (busy_tail[7] !== 1'b1 || busy_tail[22] !== 1'b1 || busy_tail[23] !== 1'b0) begin
            errors++;
            $display("FAIL coin5_busy: busy@7=%b @22=%b @23=%b, want 1 1 0",
                     busy_tail[7], busy_tail[22], busy_tail[23]);
        end
    endtask

    task automatic test_coin10_and_reject();
        drive_pulse(80, 30, -1);
        vectors++;
        if (n10 !== 1 || n5 !== 0 || nrej !== 0) begin
            errors++;
            $display("FAIL coin10: n10=%0d n5=%0d rej=%0d, want 1/0/0", n10, n5, nrej);
        end
        drive_pulse(50, 30, -1);
        vectors++;
        if (n5 + n10 !== 0 || nrej !== 1 || reject_cnt !== 8'd1) begin
            errors++;
            $display("FAIL width50_reject: coins=%0d rej=%0d cnt=%0d, want 0/1/1",
                     n5 + n10, nrej, reject_cnt);
        end
    endtask

    task automatic test_windows();
        int w   [7] = '{19, 20, 40, 41, 59, 60, 100};
        int exp [7] = '{0, 1, 1, 0, 0, 2, 2};
        for (int i = 0; i < 7; i++) begin
            drive_pulse(w[i], 30, -1);
            vectors++;
            if (n5 !== (exp[i] == 1 ? 1 : 0) || n10 !== (exp[i] == 2 ? 1 : 0) ||
                nrej !== (exp[i] == 0 ? 1 : 0) || both !== 0 || n11 !== 0) begin
                errors++;
                $display("FAIL window_w%0d: n5=%0d n10=%0d rej=%0d both=%0d, want class %0d",
                         w[i], n5, n10, nrej, both, exp[i]);
            end
        end
        drive_pulse(101, 30, -1);
        vectors++;
        if (n5 + n10 !== 0 || nrej !== 1) begin
            errors++;
            $display("FAIL window_w101: coins=%0d rej=%0d, want 0/1", n5 + n10, nrej);
        end
    endtask

    task automatic test_glitch();
        for (int g = 1; g <= 3; g++) begin
            drive_pulse(g, 10, -1);
            vectors++;
            if (n5 + n10 + nrej + busy_any !== 0) begin
                errors++;
                $display("FAIL glitch_%0d: coins=%0d rej=%0d busy_cycles=%0d, want 0",
                         g, n5 + n10, nrej, busy_any);
            end
        end
    endtask

    task automatic test_jam();
        logic [7:0] c0;
        c0 = reject_cnt;
        drive_pulse(300, 0, -1);
        vectors++;
        if (jam !== 1'b1 || jam_seen < 30) begin
            errors++;
            $display("FAIL jam_assert: jam=%b cycles=%0d, want 1 and >=30", jam, jam_seen);
        end
        clear_stats();
        fall_k = 0;
        for (int k = 0; k < 30; k++) step();
        vectors++;
        if (jam !== 1'b0 || nrej !== 1 || n5 + n10 !== 0 || reject_cnt !== c0 + 8'd1) begin
            errors++;
            $display("FAIL jam_release: jam=%b rej=%0d coins=%0d cnt=%0d, want 0/1/0/%0d",
                     jam, nrej, n5 + n10, reject_cnt, c0 + 8'd1);
        end
    endtask

    task automatic test_accept_drop();
        drive_pulse(30, 30, 10);
        vectors++;
        if (n5 + n10 !== 0 || nrej !== 1) begin
            errors++;
            $display("FAIL accept_drop: coins=%0d rej=%0d, want 0/1", n5 + n10, nrej);
        end
    endtask

    task automatic test_back_to_back();
        drive_pulse(30, 12, -1);
        vectors++;
        if (n5 !== 1 || coin_edge !== 7) begin
            errors++;
            $display("FAIL b2b_first: n5=%0d edge=%0d, want 1 at 7", n5, coin_edge);
        end
        drive_pulse(30, 30, -1);
        vectors++;
        if (n5 + n10 !== 0 || nrej !== 1) begin
            errors++;
            $display("FAIL b2b_in_gap: coins=%0d rej=%0d, want 0/1", n5 + n10, nrej);
        end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        coin_sense = 1'b1;
        repeat (15) step();
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: busy=%b want 1", busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({coin, reject, jam, busy, reject_cnt} !== 13'd0) begin
            errors++;
            $display("FAIL rst_mid_clear: coin=%b rej=%b jam=%b busy=%b cnt=%0d, want all 0",
                     coin, reject, jam, busy, reject_cnt);
        end
        drive_pulse(14, 30, -1);
        vectors++;
        if (n5 + n10 !== 0 || nrej !== 1 || reject_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rst_mid_rest: coins=%0d rej=%0d cnt=%0d, want 0/1/1",
                     n5 + n10, nrej, reject_cnt);
        end
    endtask

    task automatic test_saturate();
        int sat_wrap = 0;
        for (int i = 0; i < 260; i++) begin
            drive_pulse(8, 26, -1);
            if (i > 0 && reject_cnt == 8'd0) sat_wrap++;
        end
        vectors++;
        if (reject_cnt !== 8'd255 || sat_wrap !== 0) begin
            errors++;
            $display("FAIL rejcnt_saturate: cnt=%0d wraps=%0d, want 255/0", reject_cnt, sat_wrap);
        end
    endtask

    initial begin
        test_reset();
        test_coin5();
        test_coin10_and_reject();
        test_windows();
        test_glitch();
        test_jam();
        test_accept_drop();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
